// File: rtl/batcharger_ctrl_gen2.sv
// Battery charger controller: trickle / constant-current / constant-voltage charge sequencing.
// Latency: state updates one clk after its inputs; mode/monitor outputs are decoded from the state register one clk later.
// Backpressure: none; thresholds are only acted on while vtok=1. Optional macro: BATCHARGER_TEMP_GUARD_EN (in-charge temperature fault).
module batcharger_ctrl_gen2 #(
  parameter int DW         = 8,
  parameter int TDIV_BITS  = 8,
  parameter int TMAX_W     = 8,
  parameter int RECHG_HYST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vtok,
  input  logic [DW-1:0]     vbat,
  input  logic [DW-1:0]     ibat,
  input  logic [DW-1:0]     tbat,
  input  logic [DW-1:0]     vcutoff,
  input  logic [DW-1:0]     vpreset,
  input  logic [DW-1:0]     tempmin,
  input  logic [DW-1:0]     tempmax,
  input  logic [TMAX_W-1:0] tmax,
  input  logic [DW-1:0]     iend,
  output logic              tc,
  output logic              cc,
  output logic              cv,
  output logic              vmonen,
  output logic              imonen,
  output logic              tmonen,
  output logic              timeout,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_TC     = 3'd2,
    S_CC     = 3'd3,
    S_CV     = 3'd4,
    S_DONE   = 3'd5,
    S_TFAULT = 3'd6
  } state_t;

  localparam logic [DW:0] HYST_EXT = (DW+1)'(RECHG_HYST);

  state_t                st;
  logic [TDIV_BITS-1:0]  presc;
  logic [TMAX_W-1:0]     timer;

  logic                  charging;
  logic                  temp_ok;
  logic                  timer_hit;
  logic                  presc_wrap;
  logic                  timer_sat;
  logic [DW:0]           rechg_diff;
  logic [DW-1:0]         rechg_lvl;

  assign state      = st;
  assign charging   = (st == S_TC) || (st == S_CC) || (st == S_CV);
  assign temp_ok    = (tbat > tempmin) && (tbat < tempmax);
  assign timer_hit  = (timer >= tmax);
  assign presc_wrap = &presc;
  assign timer_sat  = &timer;

  // Recharge level = vpreset - hysteresis, clamped at zero (borrow bit selects the clamp).
  assign rechg_diff = {1'b0, vpreset} - HYST_EXT;
  assign rechg_lvl  = rechg_diff[DW] ? '0 : rechg_diff[DW-1:0];

  // Charge FSM with charge timer, timeout flag and registered state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IDLE;
      presc   <= '0;
      timer   <= '0;
      timeout <= 1'b0;
      tc      <= 1'b0;
      cc      <= 1'b0;
      cv      <= 1'b0;
      vmonen  <= 1'b0;
      imonen  <= 1'b0;
      tmonen  <= 1'b0;
    end else begin
      // Outputs follow the state register one cycle behind.
      tc     <= (st == S_TC);
      cc     <= (st == S_CC);
      cv     <= (st == S_CV);
      vmonen <= (st == S_TC) || (st == S_CC) || (st == S_DONE);
      imonen <= (st == S_CV);
      tmonen <= (st != S_IDLE);

      // Charge time only accumulates while actually charging.
      if (charging) begin
        presc <= presc + 1'b1;
        if (presc_wrap && !timer_sat) begin
          timer <= timer + 1'b1;
        end
      end

      if (!en) begin
        st      <= S_IDLE;
        timeout <= 1'b0;
      end else if (charging && timer_hit) begin
        st      <= S_DONE;
        timeout <= 1'b1;
`ifdef BATCHARGER_TEMP_GUARD_EN
      end else if (charging && vtok && !temp_ok) begin
        st <= S_TFAULT;
`endif
      end else begin
        case (st)
          S_IDLE: begin
            st    <= S_WAIT;
            presc <= '0;
            timer <= '0;
          end
          S_WAIT: begin
            if (vtok && temp_ok) st <= S_TC;
          end
          S_TC: begin
            if (vtok && (vbat > vcutoff)) st <= S_CC;
          end
          S_CC: begin
            if (vtok && (vbat >= vpreset)) st <= S_CV;
          end
          S_CV: begin
            if (vtok && (ibat < iend)) st <= S_DONE;
          end
          S_DONE: begin
            // Low battery restarts in trickle; a moderate sag restarts in CC.
            if (vtok && ((vbat < vcutoff) || (vbat < rechg_lvl))) begin
              st      <= (vbat < vcutoff) ? S_TC : S_CC;
              presc   <= '0;
              timer   <= '0;
              timeout <= 1'b0;
            end
          end
`ifdef BATCHARGER_TEMP_GUARD_EN
          S_TFAULT: begin
            // Timer is kept so the charge budget resumes where it stopped.
            if (vtok && temp_ok) st <= S_WAIT;
          end
`endif
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule
